// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control outputs of the boot loader.
// The loader connects through the slave modport; the byte source/observer side uses master.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;
    logic [1:0]        error_code;

    modport master (
        output rx_valid,
        output rx_byte,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_reset,
        input  load_done,
        input  load_error,
        input  error_code
    );

    modport slave (
        input  rx_valid,
        input  rx_byte,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_reset,
        output load_done,
        output load_error,
        output error_code
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame into 16-bit imem writes
// and releases the core reset only after the whole image has been written and verified.
module imem_boot_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);
    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_LEN  = 2'b01;
    localparam logic [1:0] E_CSUM = 2'b10;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_W = 32'(MAX_WORDS);

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [1:0]        err_q, err_d;

    logic              ready;
    logic              accept;
    logic              last_word;
    logic [15:0]       len_w;

    always_comb begin
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM: ready = !reset;
            default:                                          ready = 1'b0;
        endcase
    end

    assign accept    = bus.rx_valid && ready;
    assign len_w     = {len_q[15:8], bus.rx_byte};
    // The counter holds words already written, so the word being completed is the last one
    // when one more write brings it up to the frame length.
    assign last_word = (32'(cnt_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        xor_d     = xor_q;
        cnt_d     = cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;

        if (accept) begin
            xor_d = xor_q ^ bus.rx_byte;
            case (state_q)
                S_LEN_HI: begin
                    len_d   = {bus.rx_byte, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = len_w;
                    if (len_w == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({16'h0000, len_w} > MAX_W) begin
                        state_d = S_ERROR;
                        err_d   = E_LEN;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    hi_d    = bus.rx_byte;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = BASE + cnt_q[ADDR_W-1:0];
                    wdata_d = {hi_q, bus.rx_byte};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_word ? S_CSUM : S_DATA_HI;
                end
                S_CSUM: begin
                    if (bus.rx_byte == xor_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = E_CSUM;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        cpu_reset_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            hi_q        <= '0;
            xor_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= BASE;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            err_q       <= E_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            xor_q       <= xor_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    assign bus.rx_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.load_done  = (state_q == S_DONE);
    assign bus.load_error = (state_q == S_ERROR);
    assign bus.error_code = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame-level reference model checked every cycle, plus
// hand-computed expectations for the directed frames.
module tb_imem_boot_loader;
    localparam int ADDR_W    = 16;
    localparam int BASE_ADDR = 0;
    localparam int MAX_WORDS = 1024;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Model: the outputs are a function of the bytes accepted since the last reset.
    logic [7:0]        acc[$];
    logic [31:0]       wlog[$];
    bit                model_on = 0;
    bit                pend_rst = 0;
    bit                pend_acc = 0;
    logic [7:0]        pend_byte;
    logic [ADDR_W-1:0] exp_addr;
    logic [15:0]       exp_wdata;

    always @(negedge clk) begin
        automatic int         n;
        automatic int         nw;
        automatic bit         done;
        automatic bit         err;
        automatic bit         we;
        automatic bit         last;
        automatic bit         rdy;
        automatic logic [1:0] code;
        automatic logic [7:0] x;

        last = 0;
        if (pend_rst) begin
            acc.delete();
            model_on  = 1;
            exp_addr  = ADDR_W'(BASE_ADDR);
            exp_wdata = 16'h0000;
        end else if (pend_acc) begin
            acc.push_back(pend_byte);
            last = 1;
        end
        pend_rst = 0;
        pend_acc = 0;

        n = acc.size(); done = 0; err = 0; we = 0; code = 2'b00; nw = 0;
        if (n >= 2) begin
            nw = {acc[0], acc[1]};
            if (nw > MAX_WORDS) begin
                err = 1; code = 2'b01;
            end else if (n == 2 * nw + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x ^= acc[i];
                if (x == acc[n-1]) done = 1;
                else begin err = 1; code = 2'b10; end
            end else if (last && n >= 4 && (n % 2) == 0) begin
                we        = 1;
                exp_addr  = ADDR_W'(BASE_ADDR + (n - 4) / 2);
                exp_wdata = {acc[n-2], acc[n-1]};
            end
        end
        rdy = !reset && !done && !err;

        if (model_on) begin
            chk("rx_ready",   32'(bus.rx_ready),   32'(rdy));
            chk("load_done",  32'(bus.load_done),  32'(done));
            chk("load_error", 32'(bus.load_error), 32'(err));
            chk("error_code", 32'(bus.error_code), 32'(code));
            chk("cpu_reset",  32'(bus.cpu_reset),  32'(!done));
            chk("imem_we",    32'(bus.imem_we),    32'(we));
            chk("imem_addr",  32'(bus.imem_addr),  32'(exp_addr));
            chk("imem_wdata", 32'(bus.imem_wdata), 32'(exp_wdata));
            if (bus.imem_we === 1'b1) wlog.push_back({16'(bus.imem_addr), bus.imem_wdata});
        end

        if (reset) pend_rst = 1;
        else if (model_on && bus.rx_valid && rdy) begin
            pend_acc  = 1;
            pend_byte = bus.rx_byte;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_reset();
        @(posedge clk); #1;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wlog.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            bus.rx_valid = 1'b0;
            bus.rx_byte  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                @(posedge clk); #1;
                bus.rx_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL accept_timeout: byte 0x%0h not accepted within 40 cycles at %0t", b, $time);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input int gap_max);
        foreach (f[i]) send_byte(f[i], gap_max);
    endtask

    function automatic bq_t make_frame(input logic [15:0] w[$], input bit bad);
        bq_t f;
        logic [7:0] x;
        x = 8'h00;
        f.push_back(8'(w.size() >> 8));
        f.push_back(8'(w.size()));
        foreach (w[i]) begin
            f.push_back(w[i][15:8]);
            f.push_back(w[i][7:0]);
        end
        foreach (f[i]) x ^= f[i];
        f.push_back(bad ? ~x : x);
        return f;
    endfunction

    initial begin
        bq_t         f;
        logic [15:0] w[$];
        logic [31:0] ref_log[$];
        bit          bad;

        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;

        // Good two-word image, then bytes offered after completion must be ignored.
        drive_reset();
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_frame(f, 0);
        idle(2);
        chk("t1_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("t1_w0", wlog[0], 32'h0000_1234);
            chk("t1_w1", wlog[1], 32'h0001_ABCD);
        end
        chk("t1_done", 32'(bus.load_done), 32'd1);
        chk("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h5A;
        idle(3);
        bus.rx_valid = 1'b0;
        chk("t1_ignored", 32'(wlog.size()), 32'd2);

        // Same image with a bad checksum: words still land, load aborts.
        drive_reset();
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_frame(f, 0);
        idle(2);
        chk("t2_nwrites", 32'(wlog.size()), 32'd2);
        chk("t2_code", 32'(bus.error_code), 32'h2);
        chk("t2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("t2_ready", 32'(bus.rx_ready), 32'd0);

        // Oversized length header.
        drive_reset();
        f = '{8'h04, 8'h01};
        send_frame(f, 0);
        idle(4);
        chk("t3_nwrites", 32'(wlog.size()), 32'd0);
        chk("t3_code", 32'(bus.error_code), 32'h1);
        chk("t3_error", 32'(bus.load_error), 32'd1);

        // Empty image.
        drive_reset();
        f = '{8'h00, 8'h00, 8'h00};
        send_frame(f, 0);
        idle(2);
        chk("t4_done", 32'(bus.load_done), 32'd1);
        chk("t4_nwrites", 32'(wlog.size()), 32'd0);

        // Three-word image gap-free, then with random rx_valid gaps: identical writes.
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back(16'($urandom));
        f = make_frame(w, 0);
        drive_reset();
        send_frame(f, 0);
        idle(2);
        ref_log = wlog;
        chk("t5_ref_nwrites", 32'(ref_log.size()), 32'd3);
        drive_reset();
        send_frame(f, 3);
        idle(2);
        chk("t5_gap_nwrites", 32'(wlog.size()), 32'(ref_log.size()));
        for (int i = 0; i < 3; i++)
            if (i < wlog.size() && i < ref_log.size())
                chk("t5_gap_word", wlog[i], ref_log[i]);
        chk("t5_done", 32'(bus.load_done), 32'd1);

        // Reset after three data bytes, then a fresh one-word frame.
        drive_reset();
        f = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame(f, 0);
        drive_reset();
        f = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
        send_frame(f, 0);
        idle(2);
        chk("t6_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("t6_w0", wlog[0], 32'h0000_BEEF);
        chk("t6_done", 32'(bus.load_done), 32'd1);

        // Random frames with random gaps and random checksum corruption.
        for (int r = 0; r < 8; r++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(6, 0)); i++) w.push_back(16'($urandom));
            bad = 1'($urandom_range(1, 0));
            f = make_frame(w, bad);
            drive_reset();
            send_frame(f, 2);
            idle(2);
            chk("rand_nwrites", 32'(wlog.size()), 32'(w.size()));
            chk("rand_done", 32'(bus.load_done), 32'(!bad));
            chk("rand_error", 32'(bus.load_error), 32'(bad));
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
